// File: rtl/ifb_pkg.sv
// ifb_pkg: shared types, default sizes and helpers for the instruction fetch buffer.
//   fetch_entry_t - one queued fetch: PC plus instruction word.
//   cnt_width()   - width of a counter that must hold 0..depth inclusive.
package ifb_pkg;

    localparam int unsigned IFB_PCW   = 32;
    localparam int unsigned IFB_IW    = 32;
    localparam int unsigned IFB_DEPTH = 4;

    typedef struct packed {
        logic [IFB_PCW-1:0] pc;
        logic [IFB_IW-1:0]  instr;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifb_sync_fifo.sv
// ifb_sync_fifo: minimal synchronous FIFO storage with pointer wrap.
// Occupancy is tracked by the owner, so there are no full/empty flags here.
//   clk, rst_n - clock, asynchronous active-low reset
//   push/wdata - write one entry at the tail
//   pop        - advance the head
//   clear      - synchronous reset of both pointers (contents left as-is)
//   rdata      - current head entry
module ifb_sync_fifo
    import ifb_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign rdata = mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage between the program counter and decode.
// Issues one imem read per accepted PC, tags each request with its PC and queues
// returned instructions in order for decode. A flush kills the queue and marks all
// in-flight reads for discard.
// Optional feature (macro IFB_BYPASS_EN): a response arriving into an empty queue
// while decode is ready goes straight to decode in the same cycle.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   pc_in, pc_stall                 - current PC in; hold PC when no request fires
//   flush, halt                     - redirect (kill everything); stop issuing
//   imem_req_valid/addr/ready       - instruction memory request
//   imem_resp_valid/data            - in-order instruction memory response
//   dec_valid/instr/pc, dec_ready   - decode interface
module instr_fetch_buffer
    import ifb_pkg::*;
#(
    parameter int unsigned PCW   = IFB_PCW,
    parameter int unsigned IW    = IFB_IW,
    parameter int unsigned DEPTH = IFB_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [PCW-1:0] pc_in,
    output logic           pc_stall,
    input  logic           flush,
    input  logic           halt,
    output logic           imem_req_valid,
    output logic [PCW-1:0] imem_req_addr,
    input  logic           imem_req_ready,
    input  logic           imem_resp_valid,
    input  logic [IW-1:0]  imem_resp_data,
    output logic           dec_valid,
    output logic [IW-1:0]  dec_instr,
    output logic [PCW-1:0] dec_pc,
    input  logic           dec_ready
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW:0]       inflight;
    logic              credit_ok;
    logic              fire;
    logic              resp_keep;
    logic              bypass;
    logic              q_push;
    logic              q_pop;
    logic              deq;
    logic [PCW-1:0]    tag_head;
    logic [PCW+IW-1:0] q_head;

    // Queue slots plus in-flight reads may never exceed DEPTH, so a response
    // always has a queue slot waiting for it.
    assign inflight  = {1'b0, occ_q} + {1'b0, outst_q};
    assign credit_ok = inflight < (CW + 1)'(DEPTH);

    assign imem_req_valid = rst_n & ~halt & ~flush & credit_ok;
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid & imem_req_ready;
    assign pc_stall       = ~fire;

    assign resp_keep = imem_resp_valid & ~flush & (drop_cnt_q == '0);

`ifdef IFB_BYPASS_EN
    assign bypass = resp_keep & (occ_q == '0) & dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign q_push    = resp_keep & ~bypass;
    assign dec_valid = ((occ_q != '0) | bypass) & ~flush;
    assign deq       = dec_valid & dec_ready;
    assign q_pop     = deq & ~bypass;

    always_comb begin
        dec_instr = q_head[IW-1:0];
        dec_pc    = q_head[PCW+IW-1:IW];
        if (bypass) begin
            dec_instr = imem_resp_data;
            dec_pc    = tag_head;
        end
    end

    // Tags of flushed requests are cleared with the flush, so dropped responses
    // never own a tag; only kept responses pop one. Popping on a drop would steal
    // the tag of a post-flush request that is already in the FIFO.
    ifb_sync_fifo #(
        .Width (PCW),
        .Depth (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (resp_keep),
        .clear (flush),
        .wdata (pc_in),
        .rdata (tag_head)
    );

    ifb_sync_fifo #(
        .Width (PCW + IW),
        .Depth (DEPTH)
    ) u_instr_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .clear (flush),
        .wdata ({tag_head, imem_resp_data}),
        .rdata (q_head)
    );

    always_comb begin
        occ_d      = occ_q;
        outst_d    = outst_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            // Every read still in flight after this cycle must be discarded.
            occ_d      = '0;
            outst_d    = outst_q - CW'(imem_resp_valid);
            drop_cnt_d = outst_q - CW'(imem_resp_valid);
        end else begin
            occ_d   = occ_q + CW'(q_push) - CW'(q_pop);
            outst_d = outst_q + CW'(fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            outst_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (inflight <= (CW + 1)'(DEPTH));
            assert (!(q_push && (occ_q == CW'(DEPTH))));
            assert (!(imem_resp_valid && (outst_q == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;
    import ifb_pkg::*;

    localparam int unsigned PCW   = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PCW-1:0] pc_in = '0;
    logic           pc_stall;
    logic           flush = 1'b0;
    logic           halt = 1'b0;
    logic           imem_req_valid;
    logic [PCW-1:0] imem_req_addr;
    logic           imem_req_ready = 1'b1;
    logic           imem_resp_valid = 1'b0;
    logic [IW-1:0]  imem_resp_data = '0;
    logic           dec_valid;
    logic [IW-1:0]  dec_instr;
    logic [PCW-1:0] dec_pc;
    logic           dec_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .PCW   (PCW),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_in           (pc_in),
        .pc_stall        (pc_stall),
        .flush           (flush),
        .halt            (halt),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_ready       (dec_ready)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;

    typedef struct {
        bit rst;
        bit dr;
        bit h;
        bit rv;
        bit dv;
        bit st;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           lat = 1;
    int           n_fire = 0;
    int           n_deq = 0;
    int           n_deq0;
    mem_rsp_t     mem_q[$];
    fetch_entry_t exp_q[$];
    vec_t         vecs[18];

    logic        s_req_valid, s_dec_valid, s_pc_stall, s_fire, s_deq;
    logic [31:0] s_dec_pc, s_dec_instr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle: sample at negedge, score, advance, drive memory model.
    task automatic tick();
        fetch_entry_t e;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_dec_valid = dec_valid;
        s_pc_stall  = pc_stall;
        s_fire      = imem_req_valid & imem_req_ready;
        s_deq       = dec_valid & dec_ready;
        s_dec_pc    = dec_pc;
        s_dec_instr = dec_instr;
        if (s_deq) begin
            n_deq++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc %0h want nothing (cycle %0d)", dec_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", s_dec_pc, e.pc);
                check("dec_instr", s_dec_instr, e.instr);
            end
        end
        if (flush) begin
            exp_q.delete();
        end else if (s_fire) begin
            exp_q.push_back('{pc: imem_req_addr, instr: mem_data(imem_req_addr)});
        end
        if (s_fire) begin
            n_fire++;
            mem_q.push_back('{due: cyc + lat, data: mem_data(imem_req_addr)});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_fire) pc_in = pc_in + 32'd4;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end
    endtask

    // Called at posedge+1; memory is reset along with the DUT.
    task automatic do_reset();
        rst_n           = 1'b0;
        flush           = 1'b0;
        halt            = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pc_in           = '0;
        mem_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_pc_stall", pc_stall, 1);
        check("rst_dec_instr", dec_instr, 0);
        check("rst_dec_pc", dec_pc, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        n_fire = 0;
        n_deq  = 0;
    endtask

    task automatic wait_deq(input string name, input logic [31:0] want_pc);
        int k;
        n_deq0 = n_deq;
        k = 0;
        while (n_deq == n_deq0 && k < 20) begin
            tick();
            k++;
        end
        check({name, "_got"}, 32'(n_deq != n_deq0), 1);
        check({name, "_pc"}, s_dec_pc, want_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: streaming, 1-cycle memory.  Test 2: decode stalled for 10 cycles.
        vecs[0] = '{rst: 1, dr: 1, h: 0, rv: 1, dv: 0,   st: 0};
        vecs[1] = '{rst: 0, dr: 1, h: 0, rv: 1, dv: BYP, st: 0};
        for (int i = 2; i < 6; i++) vecs[i] = '{rst: 0, dr: 1, h: 0, rv: 1, dv: 1, st: 0};
        vecs[6] = '{rst: 1, dr: 0, h: 0, rv: 1, dv: 0, st: 0};
        vecs[7] = '{rst: 0, dr: 0, h: 0, rv: 1, dv: 0, st: 0};
        vecs[8] = '{rst: 0, dr: 0, h: 0, rv: 1, dv: 1, st: 0};
        vecs[9] = '{rst: 0, dr: 0, h: 0, rv: 1, dv: 1, st: 0};
        for (int i = 10; i < 16; i++) vecs[i] = '{rst: 0, dr: 0, h: 0, rv: 0, dv: 1, st: 1};
        vecs[16] = '{rst: 0, dr: 1, h: 0, rv: 0, dv: 1, st: 1};
        vecs[17] = '{rst: 0, dr: 1, h: 0, rv: 1, dv: 1, st: 0};

        @(posedge clk);
        #1;
        lat            = 1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) do_reset();
            dec_ready = vecs[i].dr;
            halt      = vecs[i].h;
            tick();
            check($sformatf("v%0d_req_valid", i), s_req_valid, vecs[i].rv);
            check($sformatf("v%0d_dec_valid", i), s_dec_valid, vecs[i].dv);
            check($sformatf("v%0d_pc_stall", i), s_pc_stall, vecs[i].st);
            if (i == 15) check("t2_fires", n_fire, 4);
        end
        // Remaining backlog drains in order through the scoreboard.
        for (int i = 0; i < 6; i++) tick();

        // Test 3: 3-cycle memory, flush with two reads in flight.
        lat = 3;
        do_reset();
        dec_ready = 1'b1;
        tick();
        tick();
        check("t3_outst", 32'(dut.outst_q), 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc_in = 32'h100;
        wait_deq("t3_first", 32'h100);
        for (int i = 0; i < 6; i++) tick();

        // Test 4: flush in the same cycle as a response, decode ready.
        lat = 2;
        do_reset();
        dec_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        check("t4_dv_on_flush", s_dec_valid, 0);
        flush = 1'b0;
        pc_in = 32'h200;
        check("t4_drop_cnt", 32'(dut.drop_cnt_q), 1);
        check("t4_outst", 32'(dut.outst_q), 1);
        tick();
        check("t4_stale_dropped", s_dec_valid, 0);
        wait_deq("t4_first", 32'h200);

        // Test 5: halt with two reads outstanding.
        lat = 3;
        do_reset();
        dec_ready = 1'b1;
        tick();
        tick();
        halt   = 1'b1;
        n_deq0 = n_deq;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_req_valid", s_req_valid, 0);
            check("t5_pc_stall", s_pc_stall, 1);
        end
        check("t5_delivered", n_deq - n_deq0, 2);
        halt = 1'b0;
        tick();
        check("t5_resume", s_req_valid, 1);

        // Random traffic with flushes, checked by the scoreboard.
        lat = 2;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready      = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 15) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            tick();
            if (flush) begin
                check("rand_dv_on_flush", s_dec_valid, 0);
                pc_in = 32'h1000 + ($urandom_range(0, 255) << 2);
            end
        end
        flush          = 1'b0;
        halt           = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
